// File: rtl/nonce_sweep_controller.sv
// Nonce sweep controller: walks a nonce range through an external SHA core and
// reports the first hash below target, range exhaustion, a core timeout or an abort.
module nonce_sweep_controller #(
   parameter  int unsigned WAIT_LIMIT = 1024,
   localparam int unsigned HDR_W      = 408,
   localparam int unsigned NONCE_W    = 32,
   localparam int unsigned HASH_W     = 256,
   localparam int unsigned MSG_W      = HDR_W + NONCE_W
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               abort,
   input  logic [HDR_W-1:0]   header_base,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_end,
   input  logic [HASH_W-1:0]  target,
   output logic [MSG_W-1:0]   sha_msg,
   output logic               sha_begin,
   input  logic               sha_done,
   input  logic [HASH_W-1:0]  sha_hash,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic               exhausted,
   output logic               timeout,
   output logic               aborted,
   output logic [NONCE_W-1:0] found_nonce,
   output logic [HASH_W-1:0]  found_hash,
   output logic [NONCE_W-1:0] hash_count
);

   localparam int unsigned WD_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
   // Last WAIT cycle: the watchdog would step onto WAIT_LIMIT-1 at this edge.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_LIMIT - 2);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CHECK, DONE} stateType;

   stateType           state, stateNext;
   logic [HDR_W-1:0]   headerQ, headerNext;
   logic [NONCE_W-1:0] nonceQ, nonceNext;
   logic [NONCE_W-1:0] nonceEndQ, nonceEndNext;
   logic [HASH_W-1:0]  targetQ, targetNext;
   logic [HASH_W-1:0]  hashQ, hashNext;
   logic [WD_W-1:0]    watchdog, watchdogNext;
   logic [MSG_W-1:0]   msgNext;
   logic               beginNext, busyNext, doneNext;
   logic               foundNext, exhaustedNext, timeoutNext, abortedNext;
   logic [NONCE_W-1:0] foundNonceNext;
   logic [HASH_W-1:0]  foundHashNext;
   logic [NONCE_W-1:0] hashCountNext;
   logic               abortHit;

   assign abortHit = abort && (state inside {LOAD, START, WAIT, CHECK});

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state       <= IDLE;
         headerQ     <= '0;
         nonceQ      <= '0;
         nonceEndQ   <= '0;
         targetQ     <= '0;
         hashQ       <= '0;
         watchdog    <= '0;
         sha_msg     <= '0;
         sha_begin   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         exhausted   <= 1'b0;
         timeout     <= 1'b0;
         aborted     <= 1'b0;
         found_nonce <= '0;
         found_hash  <= '0;
         hash_count  <= '0;
      end else begin
         state       <= stateNext;
         headerQ     <= headerNext;
         nonceQ      <= nonceNext;
         nonceEndQ   <= nonceEndNext;
         targetQ     <= targetNext;
         hashQ       <= hashNext;
         watchdog    <= watchdogNext;
         sha_msg     <= msgNext;
         sha_begin   <= beginNext;
         busy        <= busyNext;
         done        <= doneNext;
         found       <= foundNext;
         exhausted   <= exhaustedNext;
         timeout     <= timeoutNext;
         aborted     <= abortedNext;
         found_nonce <= foundNonceNext;
         found_hash  <= foundHashNext;
         hash_count  <= hashCountNext;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateNext      = state;
      headerNext     = headerQ;
      nonceNext      = nonceQ;
      nonceEndNext   = nonceEndQ;
      targetNext     = targetQ;
      hashNext       = hashQ;
      watchdogNext   = watchdog;
      msgNext        = sha_msg;
      beginNext      = 1'b0;
      busyNext       = 1'b0;
      doneNext       = 1'b0;
      foundNext      = found;
      exhaustedNext  = exhausted;
      timeoutNext    = timeout;
      abortedNext    = aborted;
      foundNonceNext = found_nonce;
      foundHashNext  = found_hash;
      hashCountNext  = hash_count;

      if (abortHit) begin
         abortedNext = 1'b1;
         stateNext   = DONE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  headerNext     = header_base;
                  nonceNext      = nonce_start;
                  nonceEndNext   = nonce_end;
                  targetNext     = target;
                  msgNext        = {header_base, nonce_start};
                  foundNext      = 1'b0;
                  exhaustedNext  = 1'b0;
                  timeoutNext    = 1'b0;
                  abortedNext    = 1'b0;
                  foundNonceNext = '0;
                  foundHashNext  = '0;
                  hashCountNext  = '0;
                  stateNext      = LOAD;
               end
            end
            LOAD: begin
               beginNext = 1'b1;
               stateNext = START;
            end
            START: begin
               watchdogNext = '0;
               stateNext    = WAIT;
            end
            WAIT: begin
               if (sha_done) begin
                  hashNext  = sha_hash;
                  stateNext = CHECK;
               end else if (watchdog == WD_LAST) begin
                  timeoutNext = 1'b1;
                  stateNext   = DONE;
               end else begin
                  watchdogNext = watchdog + WD_W'(1);
               end
            end
            CHECK: begin
               if (hash_count != {NONCE_W{1'b1}}) begin
                  hashCountNext = hash_count + NONCE_W'(1);
               end
               if (hashQ < targetQ) begin
                  foundNext      = 1'b1;
                  foundNonceNext = nonceQ;
                  foundHashNext  = hashQ;
                  stateNext      = DONE;
               end else if (nonceQ == nonceEndQ) begin
                  exhaustedNext = 1'b1;
                  stateNext     = DONE;
               end else begin
                  // Natural 32-bit overflow gives the wrap through 0.
                  nonceNext = nonceQ + NONCE_W'(1);
                  msgNext   = {headerQ, nonceQ + NONCE_W'(1)};
                  stateNext = LOAD;
               end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end

      busyNext = (stateNext != IDLE);
      doneNext = (stateNext == DONE);
   end

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Directed bench for nonce_sweep_controller with a behavioural SHA core whose
// latency, done-hold length and per-nonce hash are set by each scenario.
module tb_nonce_sweep_controller;

   localparam int unsigned LIMIT = 8;
   localparam logic [407:0] HDR_A = {51{8'h5A}};
   localparam logic [407:0] HDR_B = {51{8'hC3}};
   localparam logic [407:0] HDR_C = {51{8'h3C}};

   logic         clk = 1'b0;
   logic         n_rst, start, abort;
   logic [407:0] header_base;
   logic [31:0]  nonce_start, nonce_end;
   logic [255:0] target;
   logic [439:0] sha_msg;
   logic         sha_begin, sha_done;
   logic [255:0] sha_hash;
   logic         busy, done, found, exhausted, timeout, aborted;
   logic [31:0]  found_nonce;
   logic [255:0] found_hash;
   logic [31:0]  hash_count;

   int total = 0;
   int bad   = 0;

   bit           shaEnable;
   int           shaLatency, shaHold;
   logic [31:0]  hitNonce;
   logic [255:0] hitHash;
   int           pendCnt, holdCnt;
   logic [31:0]  pendNonce;
   logic [31:0]  beginQ[$];
   logic [407:0] lastHdr;

   nonce_sweep_controller #(.WAIT_LIMIT(LIMIT)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
      .header_base(header_base), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .target(target), .sha_msg(sha_msg), .sha_begin(sha_begin), .sha_done(sha_done),
      .sha_hash(sha_hash), .busy(busy), .done(done), .found(found),
      .exhausted(exhausted), .timeout(timeout), .aborted(aborted),
      .found_nonce(found_nonce), .found_hash(found_hash), .hash_count(hash_count)
   );

   always #5 clk = ~clk;

   // SHA core model: answers shaLatency cycles after sha_begin, holds done shaHold cycles
   initial begin
      sha_done = 1'b0; sha_hash = '0; pendCnt = 0; holdCnt = 0; pendNonce = '0;
      forever begin
         @(negedge clk);
         if (holdCnt > 0) begin
            holdCnt--;
            if (holdCnt == 0) sha_done = 1'b0;
         end
         if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) begin
               sha_hash = (pendNonce == hitNonce) ? hitHash : {256{1'b1}};
               sha_done = 1'b1;
               holdCnt  = shaHold;
            end
         end
         if (sha_begin === 1'b1 && shaEnable) begin
            pendNonce = sha_msg[31:0];
            pendCnt   = shaLatency;
         end
      end
   end

   // Records the nonce and header carried by every sha_begin pulse
   initial begin
      lastHdr = '0;
      forever begin
         @(negedge clk);
         if (sha_begin === 1'b1) begin
            beginQ.push_back(sha_msg[31:0]);
            lastHdr = sha_msg[439:32];
         end
      end
   end

   task automatic startSweep(input logic [407:0] hdr, input logic [31:0] ns,
                             input logic [31:0] ne, input logic [255:0] tgt);
      @(negedge clk);
      header_base = hdr; nonce_start = ns; nonce_end = ne; target = tgt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit ok, output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic test_reset;
      n_rst = 1'b1; start = 1'b0; abort = 1'b0;
      header_base = '0; nonce_start = '0; nonce_end = '0; target = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, sha_begin, found, exhausted, timeout, aborted} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0000000",
                  {busy, done, sha_begin, found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", hash_count); end
      total++;
      if (found_nonce !== 32'd0) begin bad++; $display("FAIL reset_nonce got=%h exp=0", found_nonce); end
      total++;
      if (found_hash !== 256'd0) begin bad++; $display("FAIL reset_hash got=%h exp=0", found_hash); end
      total++;
      if (sha_msg !== 440'd0) begin bad++; $display("FAIL reset_msg got=%h exp=0", sha_msg); end
      n_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_exhaust;
      int base, cycles;
      bit ok;
      shaEnable = 1'b1; shaLatency = 2; shaHold = 1; hitNonce = 32'hDEAD_BEEF; hitHash = 256'd1;
      base = beginQ.size();
      startSweep(HDR_A, 32'd5, 32'd7, 256'd0);
      waitDone(200, ok, cycles);
      total++;
      if (!ok) begin bad++; $display("FAIL exhaust_done got=none after %0d exp=done", cycles); end
      total++;
      if (cycles != 15) begin bad++; $display("FAIL exhaust_latency got=%0d exp=15", cycles); end
      total++;
      if ({busy, found, exhausted, timeout, aborted} !== 5'b10100) begin
         bad++; $display("FAIL exhaust_flags got=%b exp=10100", {busy, found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd3) begin bad++; $display("FAIL exhaust_count got=%0d exp=3", hash_count); end
      total++;
      if (beginQ.size() - base != 3) begin
         bad++; $display("FAIL exhaust_begins got=%0d exp=3", beginQ.size() - base);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (beginQ.size() <= base + i || beginQ[base + i] !== 32'(5 + i)) begin
            bad++; $display("FAIL exhaust_nonce%0d got=%h exp=%h", i, beginQ[base + i], 32'(5 + i));
         end
      end
      total++;
      if (lastHdr !== HDR_A) begin bad++; $display("FAIL exhaust_header got=%h exp=%h", lastHdr, HDR_A); end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin bad++; $display("FAIL exhaust_pulse got=%b exp=00", {done, busy}); end
      repeat (3) @(negedge clk);
      total++;
      if ({exhausted, hash_count} !== {1'b1, 32'd3}) begin
         bad++; $display("FAIL exhaust_hold got=%b/%0d exp=1/3", exhausted, hash_count);
      end
   endtask

   task automatic test_hit;
      int base, cycles;
      bit ok;
      shaEnable = 1'b1; shaLatency = 1; shaHold = 1; hitNonce = 32'h10; hitHash = 256'd1;
      base = beginQ.size();
      startSweep(HDR_B, 32'h0E, 32'hFF, 256'd2);
      waitDone(300, ok, cycles);
      total++;
      if (!ok) begin bad++; $display("FAIL hit_done got=none after %0d exp=done", cycles); end
      total++;
      if (cycles != 12) begin bad++; $display("FAIL hit_latency got=%0d exp=12", cycles); end
      total++;
      if ({busy, found, exhausted, timeout, aborted} !== 5'b11000) begin
         bad++; $display("FAIL hit_flags got=%b exp=11000", {busy, found, exhausted, timeout, aborted});
      end
      total++;
      if (found_nonce !== 32'h10) begin bad++; $display("FAIL hit_nonce got=%h exp=00000010", found_nonce); end
      total++;
      if (found_hash !== 256'd1) begin bad++; $display("FAIL hit_hash got=%h exp=1", found_hash); end
      total++;
      if (hash_count !== 32'd3) begin bad++; $display("FAIL hit_count got=%0d exp=3", hash_count); end
      total++;
      if (beginQ.size() - base != 3) begin
         bad++; $display("FAIL hit_begins got=%0d exp=3", beginQ.size() - base);
      end
      total++;
      if (lastHdr !== HDR_B) begin bad++; $display("FAIL hit_header got=%h exp=%h", lastHdr, HDR_B); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_wrap;
      int base, cycles;
      bit ok;
      logic [31:0] expN [4];
      expN = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      shaEnable = 1'b1; shaLatency = 1; shaHold = 1; hitNonce = 32'h5555_0000; hitHash = 256'd1;
      base = beginQ.size();
      startSweep(HDR_C, 32'hFFFF_FFFE, 32'd1, 256'd0);
      waitDone(300, ok, cycles);
      total++;
      if (!ok) begin bad++; $display("FAIL wrap_done got=none after %0d exp=done", cycles); end
      total++;
      if ({found, exhausted, timeout, aborted} !== 4'b0100) begin
         bad++; $display("FAIL wrap_flags got=%b exp=0100", {found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", hash_count); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (beginQ.size() <= base + i || beginQ[base + i] !== expN[i]) begin
            bad++; $display("FAIL wrap_nonce%0d got=%h exp=%h", i, beginQ[base + i], expN[i]);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout;
      int base, cycles;
      bit ok;
      shaEnable = 1'b0;
      base = beginQ.size();
      startSweep(HDR_A, 32'd0, 32'd3, 256'd0);
      cycles = 0;
      while (sha_begin !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      total++;
      if (sha_begin !== 1'b1) begin bad++; $display("FAIL timeout_begin got=%b exp=1", sha_begin); end
      waitDone(50, ok, cycles);
      total++;
      if (!ok || cycles != 8) begin
         bad++; $display("FAIL timeout_latency got=%0d done=%b exp=8", cycles, done);
      end
      total++;
      if ({busy, found, exhausted, timeout, aborted} !== 5'b10010) begin
         bad++; $display("FAIL timeout_flags got=%b exp=10010", {busy, found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd0) begin bad++; $display("FAIL timeout_count got=%0d exp=0", hash_count); end
      total++;
      if (beginQ.size() - base != 1) begin
         bad++; $display("FAIL timeout_begins got=%0d exp=1", beginQ.size() - base);
      end
      shaEnable = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_abort;
      int base, cycles, nb;
      bit ok;
      shaEnable = 1'b1; shaLatency = 3; shaHold = 1; hitNonce = 32'h7777_0000; hitHash = 256'd1;
      base = beginQ.size();
      startSweep(HDR_A, 32'd0, 32'd9, 256'd0);
      nb = 0; cycles = 0;
      while (nb < 2 && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (sha_begin === 1'b1) nb++;
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (nb != 2 || done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b begins=%0d exp=1/2", done, nb); end
      total++;
      if ({busy, found, exhausted, timeout, aborted} !== 5'b10001) begin
         bad++; $display("FAIL abort_flags got=%b exp=10001", {busy, found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd1) begin bad++; $display("FAIL abort_count got=%0d exp=1", hash_count); end
      repeat (12) @(negedge clk);
      total++;
      if (beginQ.size() - base != 2 || busy !== 1'b0) begin
         bad++; $display("FAIL abort_quiet got=%0d busy=%b exp=2/0", beginQ.size() - base, busy);
      end
      total++;
      if ({aborted, hash_count} !== {1'b1, 32'd1}) begin
         bad++; $display("FAIL abort_hold got=%b/%0d exp=1/1", aborted, hash_count);
      end
      // start together with abort in IDLE must start a fresh single-nonce sweep
      base = beginQ.size();
      header_base = HDR_B; nonce_start = 32'd3; nonce_end = 32'd3; target = 256'd0;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      total++;
      if ({busy, found, exhausted, timeout, aborted} !== 5'b10000) begin
         bad++; $display("FAIL startabort_accept got=%b exp=10000", {busy, found, exhausted, timeout, aborted});
      end
      waitDone(50, ok, cycles);
      total++;
      if (!ok || {found, exhausted, timeout, aborted} !== 4'b0100) begin
         bad++; $display("FAIL single_flags got=%b done=%b exp=0100", {found, exhausted, timeout, aborted}, done);
      end
      total++;
      if (hash_count !== 32'd1 || beginQ.size() - base != 1) begin
         bad++; $display("FAIL single_count got=%0d begins=%0d exp=1/1", hash_count, beginQ.size() - base);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid_wait;
      int base, cycles;
      shaEnable = 1'b1; shaLatency = 4; shaHold = 1; hitNonce = 32'd0; hitHash = 256'd0;
      base = beginQ.size();
      startSweep(HDR_C, 32'd0, 32'd5, 256'd9);
      cycles = 0;
      while (sha_begin !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      n_rst = 1'b0;
      total++;
      if ({busy, done, sha_begin, found, exhausted, timeout, aborted} !== 7'b0) begin
         bad++; $display("FAIL rstwait_flags got=%b exp=0000000",
                         {busy, done, sha_begin, found, exhausted, timeout, aborted});
      end
      total++;
      if ({hash_count, found_nonce} !== 64'd0 || found_hash !== 256'd0 || sha_msg !== 440'd0) begin
         bad++; $display("FAIL rstwait_data got=%h/%h/%h exp=0", hash_count, found_nonce, sha_msg[31:0]);
      end
      repeat (8) @(negedge clk);
      total++;
      if ({busy, found, hash_count} !== 34'd0 || beginQ.size() - base != 1) begin
         bad++; $display("FAIL rstwait_late got=%b/%b/%0d begins=%0d exp=0/0/0/1",
                         busy, found, hash_count, beginQ.size() - base);
      end
   endtask

   task automatic test_back_to_back;
      int base, cycles;
      bit ok;
      shaEnable = 1'b1; shaLatency = 1; shaHold = 3; hitNonce = 32'h9999_0000; hitHash = 256'd1;
      base = beginQ.size();
      startSweep(HDR_A, 32'h20, 32'h22, 256'd0);
      nonce_start = 32'h99; nonce_end = 32'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(100, ok, cycles);
      total++;
      if (!ok || cycles != 11) begin
         bad++; $display("FAIL b2b_latency got=%0d done=%b exp=11", cycles, done);
      end
      total++;
      if ({found, exhausted, timeout, aborted} !== 4'b0100) begin
         bad++; $display("FAIL b2b_flags got=%b exp=0100", {found, exhausted, timeout, aborted});
      end
      total++;
      if (hash_count !== 32'd3 || beginQ.size() - base != 3) begin
         bad++; $display("FAIL b2b_count got=%0d begins=%0d exp=3/3", hash_count, beginQ.size() - base);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (beginQ.size() <= base + i || beginQ[base + i] !== 32'(32'h20 + i)) begin
            bad++; $display("FAIL b2b_nonce%0d got=%h exp=%h", i, beginQ[base + i], 32'(32'h20 + i));
         end
      end
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b0 || hash_count !== 32'd3) begin
         bad++; $display("FAIL b2b_idle got=%b/%0d exp=0/3", busy, hash_count);
      end
   endtask

   initial begin
      shaEnable = 1'b0; shaLatency = 1; shaHold = 1; hitNonce = '0; hitHash = '0;
      test_reset();
      test_exhaust();
      test_hit();
      test_wrap();
      test_timeout();
      test_abort();
      test_reset_mid_wait();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end

endmodule
